// File: rtl/deskew_pkg.sv
// Shared defaults and sizing helper for the systolic output deskew block.
package deskew_pkg;

  localparam int unsigned DESKEW_LANES      = 8;
  localparam int unsigned DESKEW_WIDTH      = 16;
  localparam int unsigned DESKEW_FIFO_DEPTH = 4;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned deskew_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/deskew_row_fifo.sv
// Synchronous aligned-row FIFO: push input, valid/ready pop, occupancy count.
module deskew_row_fifo
  import deskew_pkg::*;
#(
  parameter int unsigned DATA_W = DESKEW_LANES * DESKEW_WIDTH,
  parameter int unsigned DEPTH  = DESKEW_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  output logic                           pop_valid,
  input  logic                           pop_ready,
  output logic [DATA_W-1:0]              pop_data,
  output logic [deskew_cnt_w(DEPTH)-1:0] count
);

  localparam int unsigned CW = deskew_cnt_w(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign do_pop    = pop_valid && pop_ready;
  // A push into a full FIFO is only taken when a pop frees the slot that edge.
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_out_deskew.sv
// Re-aligns skewed systolic array output rows, buffers them and issues launch credit.
// Optional sticky protocol-violation detection is built when DESKEW_OVF_DET_EN is defined.
module systolic_out_deskew
  import deskew_pkg::*;
#(
  parameter int unsigned LANES      = DESKEW_LANES,
  parameter int unsigned WIDTH      = DESKEW_WIDTH,
  parameter int unsigned FIFO_DEPTH = DESKEW_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   ovf_err
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned CW = deskew_cnt_w(FIFO_DEPTH);
  localparam int unsigned SW = CW + 1;

  logic          launch;
  logic          wr_en;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [DW-1:0] aligned;

  assign launch   = in_valid && in_ready;
  // Credit depends only on registered occupancy, never on out_ready.
  assign in_ready = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);

  // Lane i is delayed LANES-1-i cycles so every lane lands at t+LANES-1.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned DLY = LANES - 1 - i;
    if (DLY == 0) begin : g_direct
      assign aligned[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [WIDTH-1:0] dly [DLY];
      always_ff @(posedge clk) begin
        dly[0] <= in_data[i*WIDTH +: WIDTH];
        for (int k = 1; k < int'(DLY); k++) dly[k] <= dly[k-1];
      end
      assign aligned[i*WIDTH +: WIDTH] = dly[DLY-1];
    end
  end

  if (LANES > 1) begin : g_vpipe
    logic [LANES-2:0] vpipe;
    always_ff @(posedge clk) begin
      if (rst) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= launch;
        for (int k = 1; k < int'(LANES) - 1; k++) vpipe[k] <= vpipe[k-1];
      end
    end
    assign wr_en = vpipe[LANES-2];
  end else begin : g_novpipe
    assign wr_en = launch;
  end

  // Rows launched but not yet written into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({launch, wr_en})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  deskew_row_fifo #(
    .DATA_W (DW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (aligned),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (out_data),
    .count     (fifo_count)
  );

`ifdef DESKEW_OVF_DET_EN
  logic ovf_q;
  logic full_push;

  assign full_push = wr_en && (fifo_count == CW'(FIFO_DEPTH)) && !(out_valid && out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((in_valid && !in_ready) || full_push) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_out_deskew.sv
// Randomized self-checking bench for systolic_out_deskew against a row-queue reference model.
module tb_systolic_out_deskew;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = LANES * WIDTH;
  localparam int unsigned HMAX  = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ovf_err;

  always #5 clk = ~clk;

  systolic_out_deskew #(
    .LANES      (LANES),
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf_err   (ovf_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: in_data seen at each edge, and launch edges of rows not yet popped.
  logic [DW-1:0] hist [HMAX];
  int            lq [$];
  bit            known   = 1'b0;
  bit            ovf_exp = 1'b0;

  logic          obs_in_ready;
  logic          obs_out_valid;
  logic          obs_ovf;
  logic [DW-1:0] obs_out_data;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [WIDTH-1:0] x);
    return {LANES{x}};
  endfunction

  function automatic logic [DW-1:0] rnd_row();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return DW'(r);
  endfunction

  // Row launched at edge t: lane i is whatever in_data held at edge t+i.
  function automatic logic [DW-1:0] row_of(input int t);
    logic [DW-1:0] r;
    logic [DW-1:0] h;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      h = hist[(t + i) % HMAX];
      r[i*WIDTH +: WIDTH] = h[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // One clock: check outputs ahead of edge cyc, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy, input logic r);
    logic exp_rdy;
    logic exp_vld;
    @(negedge clk);
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_out_data  = out_data;
    obs_ovf       = ovf_err;
    exp_rdy = (lq.size() < int'(DEPTH));
    exp_vld = (lq.size() > 0) && (lq[0] + int'(LANES) - 1 < cyc);
    if (known) begin
      chk("in_ready", DW'(in_ready), DW'(exp_rdy));
      chk("out_valid", DW'(out_valid), DW'(exp_vld));
      if (exp_vld) chk("out_data", out_data, row_of(lq[0]));
      chk("ovf_err", DW'(ovf_err), DW'(ovf_exp));
    end
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    hist[cyc % HMAX] = d;
    if (r) begin
      lq.delete();
      ovf_exp = 1'b0;
      known   = 1'b1;
    end else begin
      if (exp_vld && ordy) void'(lq.pop_front());
      if (v && exp_rdy) lq.push_back(cyc);
`ifdef DESKEW_OVF_DET_EN
      if (v && !exp_rdy) ovf_exp = 1'b1;
`endif
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, rnd_row(), ordy, 1'b0);
  endtask

  initial begin
    int n;
    logic exp_ovf_hold;

    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("reset_in_ready", DW'(obs_in_ready), DW'(1));
    chk("reset_out_valid", DW'(obs_out_valid), DW'(0));

    // Single row with a known lane pattern.
    cycle(1'b1, rep(16'h0010), 1'b1, 1'b0);
    for (int k = 1; k < int'(LANES); k++) cycle(1'b0, rep(WIDTH'(16'h0010 + k)), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("single_valid", DW'(obs_out_valid), DW'(1));
    chk("single_data", obs_out_data, 64'h0013_0012_0011_0010);
    idle(2, 1'b1);

    // Streaming: launch whenever credit is available, six rows total.
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      if (lq.size() < int'(DEPTH)) n++;
      cycle(lq.size() < int'(DEPTH), rnd_row(), 1'b1, 1'b0);
    end
    chk("stream_launched", DW'(n), DW'(6));
    n = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, rnd_row(), 1'b1, 1'b0);
      if (obs_out_valid) n++;
    end
    chk("stream_tail_empty", DW'(lq.size()), DW'(0));

    // Backpressure: launch every cycle while credit lasts.
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1 && (lq.size() < int'(DEPTH)), rnd_row(), 1'b0, 1'b0);
      if (in_valid && obs_in_ready) n++;
    end
    chk("bp_accepted", DW'(n), DW'(4));
    chk("bp_in_ready_low", DW'(obs_in_ready), DW'(0));
    n = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, rnd_row(), 1'b1, 1'b0);
      if (obs_out_valid) n++;
    end
    chk("bp_drained", DW'(n), DW'(4));

    // Concurrent push and pop: fourth row's write coincides with first pop.
    for (int k = 0; k < int'(LANES); k++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    cycle(1'b0, rnd_row(), 1'b0, 1'b0);
    cycle(1'b0, rnd_row(), 1'b0, 1'b0);
    idle(10, 1'b1);

    // Reset while two rows are in flight.
    cycle(1'b1, rnd_row(), 1'b1, 1'b0);
    cycle(1'b1, rnd_row(), 1'b1, 1'b0);
    cycle(1'b0, rnd_row(), 1'b1, 1'b1);
    cycle(1'b1, rnd_row(), 1'b1, 1'b0);
    chk("rst_mid_in_ready", DW'(obs_in_ready), DW'(1));
    idle(4, 1'b1);
    chk("rst_mid_new_row", DW'(obs_out_valid), DW'(1));
    idle(3, 1'b1);

    // Violation: push past the credit limit.
    for (int k = 0; k < 6; k++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    idle(10, 1'b1);
`ifdef DESKEW_OVF_DET_EN
    exp_ovf_hold = 1'b1;
`else
    exp_ovf_hold = 1'b0;
`endif
    chk("ovf_held", DW'(obs_ovf), DW'(exp_ovf_hold));
    cycle(1'b0, rnd_row(), 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("ovf_cleared", DW'(obs_ovf), DW'(0));

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 99) < 60, rnd_row(), $urandom_range(0, 99) < 70,
            $urandom_range(0, 299) == 0);
    end
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
